// File: rtl/fx_pt_sub_rnd_pipe.sv
// fx_pt_sub_rnd_pipe: three-stage fixed-point subtractor, diff = a - b, with
// round-half-up and saturation to a DIW.DFW result.
//
// Stages: S1 captures the raw operands, S2 aligns both operands to a common
// fraction width and subtracts exactly, S3 rounds and saturates into the
// output register.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high (in_valid/in_ready upstream, out_valid/out_ready downstream).
// A stage may load when it is empty or when the stage after it loads in the
// same cycle, so in_ready ripples combinationally back from out_ready and the
// pipe runs at one result per cycle without bubbles. While out_valid is high
// and out_ready is low, out_diff/out_ovf hold their values.
module fx_pt_sub_rnd_pipe #(
  parameter int SN  = 0,
  parameter int AIW = 2,
  parameter int AFW = 5,
  parameter int BIW = 4,
  parameter int BFW = 6,
  parameter int DIW = (AIW > BIW) ? AIW + 2 : BIW + 2,
  parameter int DFW = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AIW+AFW-1:0]     in_a,
  input  logic [BIW+BFW-1:0]     in_b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DIW+DFW-1:0]     out_diff,
  output logic                   out_ovf,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int AW  = AIW + AFW;
  localparam int BW  = BIW + BFW;
  localparam int OW  = DIW + DFW;
  localparam int MFW = (AFW > BFW) ? AFW : BFW;
  localparam int MIW = (AIW > BIW) ? AIW : BIW;
  // Exact difference: operands extended to MIW+1 integer bits, one more bit
  // so the subtraction itself cannot wrap.
  localparam int DW  = MIW + 2 + MFW;
  // Fraction bits dropped by rounding, or appended when DFW exceeds MFW.
  localparam int SH  = (MFW > DFW) ? MFW - DFW : 0;
  localparam int PAD = (DFW > MFW) ? DFW - MFW : 0;
  localparam int HSH = (SH > 0) ? SH - 1 : 0;
  // Working width: room for the half-LSB carry, the fraction pad, and the
  // signed saturation bounds of the result format.
  localparam int RW0 = DW + 1 + PAD;
  localparam int RW1 = OW + 2;
  localparam int RW  = (RW0 > RW1) ? RW0 : RW1;

  localparam logic signed [RW-1:0] HALF  = (SH > 0) ? (RW'(1) << HSH) : '0;
  localparam logic signed [RW-1:0] MAX_V = (SN != 0) ? ((RW'(1) << (OW - 1)) - RW'(1))
                                                      : ((RW'(1) << OW) - RW'(1));
  localparam logic signed [RW-1:0] MIN_V = (SN != 0) ? ~MAX_V : '0;

  logic                 v1, v2, v3;
  logic                 en1, en2, en3;
  logic [AW-1:0]        s1_a;
  logic [BW-1:0]        s1_b;
  logic signed [RW-1:0] a_x, b_x, diff_c;
  logic signed [RW-1:0] s2_diff;
  logic signed [RW-1:0] rnd_c;
  logic [OW-1:0]        sat_c;
  logic                 ovf_c;

  // Stage enables: a stage loads when empty or when its successor loads.
  always_comb begin
    en3 = !v3 || out_ready;
    en2 = !v2 || en3;
    en1 = !v1 || en2;
  end

  assign in_ready  = en1;
  assign out_valid = v3;

  // Valid bits of the three stages; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  // S1: capture raw operands on an input transfer.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_a <= in_a;
      s1_b <= in_b;
    end
  end

  // Align both operands to MFW fraction bits with sign/zero extension, then subtract.
  always_comb begin
    if (SN != 0) begin
      a_x = RW'(signed'(s1_a));
      b_x = RW'(signed'(s1_b));
    end else begin
      a_x = RW'(s1_a);
      b_x = RW'(s1_b);
    end
    a_x    = a_x <<< (MFW - AFW);
    b_x    = b_x <<< (MFW - BFW);
    diff_c = a_x - b_x;
  end

  // S2: register the exact difference.
  always_ff @(posedge clk) begin
    if (en2 && v1) begin
      s2_diff <= diff_c;
    end
  end

  // Round half-up (add half LSB, arithmetic floor), rescale, then clip to range.
  always_comb begin
    rnd_c = ((s2_diff + HALF) >>> SH) <<< PAD;
    sat_c = OW'(rnd_c);
    ovf_c = 1'b0;
    if (rnd_c > MAX_V) begin
      sat_c = OW'(MAX_V);
      ovf_c = 1'b1;
    end else if (rnd_c < MIN_V) begin
      sat_c = OW'(MIN_V);
      ovf_c = 1'b1;
    end
  end

  // S3: output register, held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_diff <= '0;
      out_ovf  <= 1'b0;
    end else if (en3 && v2) begin
      out_diff <= sat_c;
      out_ovf  <= ovf_c;
    end
  end

endmodule

// File: tb/tb_fx_pt_sub_rnd_pipe.sv
// Bench for fx_pt_sub_rnd_pipe: three instances share one input stream and
// one out_ready: signed default format, signed with DIW=3 (saturation), and
// unsigned. Each has its own expected queue filled from a numeric model.
module tb_fx_pt_sub_rnd_pipe;

  logic       clk;
  logic       rst;
  logic [6:0] in_a;
  logic [9:0] in_b;
  logic       in_valid;
  logic       out_ready;

  logic [8:0] diff_d;
  logic       ovf_d, vld_d, rdy_d;
  logic [5:0] diff_3;
  logic       ovf_3, vld_3, rdy_3;
  logic [8:0] diff_u;
  logic       ovf_u, vld_u, rdy_u;

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp3_q[$];
  logic [9:0] expu_q[$];

  fx_pt_sub_rnd_pipe #(.SN(1)) u_dflt (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(rdy_d), .out_diff(diff_d), .out_ovf(ovf_d), .out_valid(vld_d),
    .out_ready(out_ready));

  fx_pt_sub_rnd_pipe #(.SN(1), .DIW(3)) u_d3 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(rdy_3), .out_diff(diff_3), .out_ovf(ovf_3), .out_valid(vld_3),
    .out_ready(out_ready));

  fx_pt_sub_rnd_pipe #(.SN(0)) u_uns (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(rdy_u), .out_diff(diff_u), .out_ovf(ovf_u), .out_valid(vld_u),
    .out_ready(out_ready));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Numeric model: values as integers in units of 2^-6, round half-up to
  // units of 2^-3 via floor((d+4)/8), clip to the DIW.3 range.
  // Returns {ovf, diff bits zero-extended to 9}.
  function automatic logic [9:0] ref_sub(input int sn, input int diw,
                                         input logic [6:0] a, input logic [9:0] b);
    longint av, bv, d, r, hi, lo;
    logic ovf;
    logic [8:0] res;
    av = longint'(a);
    if (sn != 0 && a[6]) av = av - 128;
    av = av * 2;
    bv = longint'(b);
    if (sn != 0 && b[9]) bv = bv - 1024;
    d = av - bv;
    r = (d + 4) >>> 3;
    if (sn != 0) begin
      hi = (longint'(1) << (diw + 2)) - 1;
      lo = -(longint'(1) << (diw + 2));
    end else begin
      hi = (longint'(1) << (diw + 3)) - 1;
      lo = 0;
    end
    ovf = 1'b0;
    if (r > hi) begin r = hi; ovf = 1'b1; end
    else if (r < lo) begin r = lo; ovf = 1'b1; end
    res = 9'(r & ((longint'(1) << (diw + 3)) - 1));
    return {ovf, res};
  endfunction

  // scoreboard: handshakes seen at negedge complete at the next posedge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp3_q.delete();
      expu_q.delete();
    end else begin
      if (in_valid && rdy_d) begin
        exp_q.push_back(ref_sub(1, 6, in_a, in_b));
        exp3_q.push_back(ref_sub(1, 3, in_a, in_b));
        expu_q.push_back(ref_sub(0, 6, in_a, in_b));
      end
      if (vld_d && out_ready) begin
        chk("sb_dflt_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_dflt", {ovf_d, diff_d}, exp_q.pop_front());
      end
      if (vld_3 && out_ready) begin
        chk("sb_d3_pending", 32'(exp3_q.size() != 0), 1);
        if (exp3_q.size() != 0) chk("sb_d3", {ovf_3, 3'b000, diff_3}, exp3_q.pop_front());
      end
      if (vld_u && out_ready) begin
        chk("sb_uns_pending", 32'(expu_q.size() != 0), 1);
        if (expu_q.size() != 0) chk("sb_uns", {ovf_u, diff_u}, expu_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one operand into an empty pipe with out_ready=1, checks 3-cycle latency
  task automatic run_vec(input logic [6:0] a, input logic [9:0] b);
    out_ready = 1'b1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    chk("vec_in_ready", rdy_d, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("lat_not_early", vld_d, 0);
    step();
    chk("lat_valid", vld_d, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0 || expu_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_dflt_empty"}, exp_q.size(), 0);
    chk({tag, "_d3_empty"}, exp3_q.size(), 0);
    chk({tag, "_uns_empty"}, expu_q.size(), 0);
  endtask

  initial begin
    int acc;
    logic held;
    logic [6:0] edge_a [4];
    logic [9:0] edge_b [4];
    edge_a = '{7'h00, 7'h7F, 7'h40, 7'h3F};
    edge_b = '{10'h000, 10'h3FF, 10'h200, 10'h1FF};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    repeat (3) step();
    chk("rst_out_valid", vld_d, 0);
    chk("rst_out_diff", diff_d, 0);
    chk("rst_out_ovf", ovf_d, 0);
    rst = 1'b0;
    chk("rst_in_ready", rdy_d, 1);

    // basic subtract
    run_vec(7'h30, 10'h010);
    chk("t1_dflt", {ovf_d, diff_d}, 10'h00A);
    // rounding cases
    run_vec(7'h02, 10'h000);
    chk("rnd_1_16", {ovf_d, diff_d}, 10'h001);
    run_vec(7'h01, 10'h000);
    chk("rnd_1_32", {ovf_d, diff_d}, 10'h000);
    run_vec(7'h00, 10'h008);
    chk("rnd_neg_1_8", {ovf_d, diff_d}, 10'h1FF);
    run_vec(7'h00, 10'h004);
    chk("rnd_neg_1_16", {ovf_d, diff_d}, 10'h000);
    // saturation with DIW=3
    run_vec(7'h30, 10'h300);
    chk("sat_hi_d3", {ovf_3, diff_3}, 7'h5F);
    run_vec(7'h30, 10'h1F0);
    chk("sat_lo_d3", {ovf_3, diff_3}, 7'h60);
    // unsigned
    run_vec(7'h10, 10'h040);
    chk("uns_neg", {ovf_u, diff_u}, 10'h200);
    run_vec(7'h60, 10'h040);
    chk("uns_pos", {ovf_u, diff_u}, 10'h010);
    drain("dir");

    // backpressure: 5 offers with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 7'($urandom);
    in_b = 10'($urandom);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      held = rdy_d;
      step();
      if (held) begin
        acc++;
        in_a = 7'($urandom);
        in_b = 10'($urandom);
      end
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready", rdy_d, 0);
    chk("bp_out_held_valid", vld_d, 1);
    drain("bp");

    // reset with the pipe full
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      in_a = 7'($urandom);
      in_b = 10'($urandom);
      step();
    end
    chk("mid_full", vld_d, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    chk("mid_rst_valid", vld_d, 0);
    chk("mid_rst_diff", diff_d, 0);
    chk("mid_rst_ovf", ovf_d, 0);
    chk("mid_rst_valid_uns", vld_u, 0);
    rst = 1'b0;
    chk("mid_rst_in_ready", rdy_d, 1);
    out_ready = 1'b1;
    repeat (8) step();
    chk("mid_no_stale", vld_d, 0);

    // random traffic with random backpressure
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      held = in_valid && !rdy_d;
      step();
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) begin
          in_a = edge_a[$urandom_range(0, 3)];
          in_b = edge_b[$urandom_range(0, 3)];
        end else begin
          in_a = 7'($urandom);
          in_b = 10'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      chk("rnd_ready_agree", {rdy_3, rdy_u}, {rdy_d, rdy_d});
    end
    drain("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
